// File: rtl/present_pkg.sv
// Shared constants, FSM encoding and PRESENT nibble/bit-permutation helpers
// for the single-block PRESENT-80 decryption sequencer.
package present_pkg;

    localparam int ROUNDS = 31;
    localparam int KEY_W  = 80;
    localparam int BLK_W  = 64;

    localparam logic [4:0] RC_LAST  = 5'(ROUNDS);
    localparam logic [4:0] RC_FIRST = 5'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEYEXP,
        ST_WHITEN,
        ST_ROUND,
        ST_DONE
    } fsm_state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] r;
        case (x)
            4'h0: r = 4'hC;
            4'h1: r = 4'h5;
            4'h2: r = 4'h6;
            4'h3: r = 4'hB;
            4'h4: r = 4'h9;
            4'h5: r = 4'h0;
            4'h6: r = 4'hA;
            4'h7: r = 4'hD;
            4'h8: r = 4'h3;
            4'h9: r = 4'hE;
            4'hA: r = 4'hF;
            4'hB: r = 4'h8;
            4'hC: r = 4'h4;
            4'hD: r = 4'h7;
            4'hE: r = 4'h1;
            default: r = 4'h2;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] r;
        case (x)
            4'h0: r = 4'h5;
            4'h1: r = 4'hE;
            4'h2: r = 4'hF;
            4'h3: r = 4'h8;
            4'h4: r = 4'hC;
            4'h5: r = 4'h1;
            4'h6: r = 4'h2;
            4'h7: r = 4'hD;
            4'h8: r = 4'hB;
            4'h9: r = 4'h4;
            4'hA: r = 4'h6;
            4'hB: r = 4'h3;
            4'hC: r = 4'h0;
            4'hD: r = 4'h7;
            4'hE: r = 4'h9;
            default: r = 4'hA;
        endcase
        return r;
    endfunction

    // Forward pLayer sends bit i to i*16 mod 63, so the inverse gathers from there.
    function automatic logic [BLK_W-1:0] p_layer_inv(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] r;
        r[BLK_W-1] = x[BLK_W-1];
        for (int i = 0; i < BLK_W - 1; i++) begin
            r[i] = x[(i * 16) % 63];
        end
        return r;
    endfunction

endpackage

// File: rtl/present_key_step.sv
// One PRESENT-80 key-schedule step, forward (encrypt order) or inverse,
// selected by inverse_i. Purely combinational.
module present_key_step
    import present_pkg::*;
(
    input  logic [KEY_W-1:0] key_i,
    input  logic [4:0]       rc_i,
    input  logic             inverse_i,
    output logic [KEY_W-1:0] key_o
);

    logic [KEY_W-1:0] rot_fwd;
    logic [KEY_W-1:0] key_fwd;
    logic [KEY_W-1:0] undo;
    logic [KEY_W-1:0] key_inv;

    always_comb begin
        rot_fwd = {key_i[18:0], key_i[79:19]};
        key_fwd = {sbox(rot_fwd[79:76]), rot_fwd[75:20],
                   rot_fwd[19:15] ^ rc_i, rot_fwd[14:0]};

        // Undo in reverse order: counter XOR, S-box, then rotate back by 61.
        undo          = key_i;
        undo[19:15]   = key_i[19:15] ^ rc_i;
        undo[79:76]   = sbox_inv(key_i[79:76]);
        key_inv       = {undo[60:0], undo[79:61]};

        key_o = inverse_i ? key_inv : key_fwd;
    end

endmodule

// File: rtl/present_dec_ctrl.sv
// PRESENT-80 single-block decryption sequencer, one round per clock.
// Optional K32 cache for repeated keys: define PRESENT_DEC_KEYCACHE_EN.
module present_dec_ctrl
    import present_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] state,
    input  logic [KEY_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out,
    output logic             busy
);

    fsm_state_e       fsm_q, fsm_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [4:0]       rc_q, rc_d;

    logic [KEY_W-1:0] key_step;
    logic             key_inverse;
    logic [BLK_W-1:0] data_perm;
    logic [BLK_W-1:0] data_sub;
    logic             cache_hit;

    assign key_inverse = (fsm_q == ST_ROUND);

    present_key_step u_key_step (
        .key_i     (key_q),
        .rc_i      (rc_q),
        .inverse_i (key_inverse),
        .key_o     (key_step)
    );

    assign data_perm = p_layer_inv(data_q);

    generate
        for (genvar gi = 0; gi < BLK_W / 4; gi++) begin : g_sbox_inv
            assign data_sub[gi*4 +: 4] = sbox_inv(data_perm[gi*4 +: 4]);
        end
    endgenerate

`ifdef PRESENT_DEC_KEYCACHE_EN
    logic [KEY_W-1:0] cache_key_q, cache_key_d;
    logic [KEY_W-1:0] cache_k32_q, cache_k32_d;
    logic [KEY_W-1:0] user_key_q, user_key_d;
    logic             cache_vld_q, cache_vld_d;

    assign cache_hit = cache_vld_q && (key == cache_key_q);

    always_comb begin
        cache_key_d = cache_key_q;
        cache_k32_d = cache_k32_q;
        cache_vld_d = cache_vld_q;
        user_key_d  = user_key_q;
        if (fsm_q == ST_IDLE && in_valid) begin
            user_key_d = key;
        end
        if (fsm_q == ST_KEYEXP && rc_q == RC_LAST) begin
            cache_key_d = user_key_q;
            cache_k32_d = key_step;
            cache_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_key_q <= '0;
            cache_k32_q <= '0;
            user_key_q  <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_key_q <= cache_key_d;
            cache_k32_q <= cache_k32_d;
            user_key_q  <= user_key_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    always_comb begin
        fsm_d  = fsm_q;
        data_d = data_q;
        key_d  = key_q;
        rc_d   = rc_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d = state;
                    key_d  = key;
                    rc_d   = RC_FIRST;
                    fsm_d  = ST_KEYEXP;
                `ifdef PRESENT_DEC_KEYCACHE_EN
                    if (cache_hit) begin
                        key_d = cache_k32_q;
                        fsm_d = ST_WHITEN;
                    end
                `endif
                end
            end
            ST_KEYEXP: begin
                key_d = key_step;
                if (rc_q == RC_LAST) begin
                    fsm_d = ST_WHITEN;
                end else begin
                    rc_d = rc_q + 5'd1;
                end
            end
            ST_WHITEN: begin
                data_d = data_q ^ key_q[79:16];
                rc_d   = RC_LAST;
                fsm_d  = ST_ROUND;
            end
            ST_ROUND: begin
                key_d  = key_step;
                data_d = data_sub ^ key_step[79:16];
                rc_d   = rc_q - 5'd1;
                if (rc_q == RC_FIRST) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= ST_IDLE;
            data_q <= '0;
            key_q  <= '0;
            rc_q   <= '0;
        end else begin
            fsm_q  <= fsm_d;
            data_q <= data_d;
            key_q  <= key_d;
            rc_q   <= rc_d;
        end
    end

    // Intermediate round data never leaves the block; out is zero until DONE.
    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign out       = out_valid ? data_q : '0;
    assign busy      = (fsm_q == ST_KEYEXP) || (fsm_q == ST_WHITEN) || (fsm_q == ST_ROUND);

endmodule

// File: tb/tb_present_dec_ctrl.sv
// Directed bench for present_dec_ctrl using published PRESENT-80 vectors;
// latency expectations follow PRESENT_DEC_KEYCACHE_EN when defined.
module tb_present_dec_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] state_in;
    logic [79:0] key_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [79:0] KEY_ZERO = 80'h0;
    localparam logic [79:0] KEY_ONES = {80{1'b1}};
    localparam logic [63:0] PT_ZERO  = 64'h0;
    localparam logic [63:0] PT_ONES  = {64{1'b1}};
    localparam int FULL_LAT = 63;
`ifdef PRESENT_DEC_KEYCACHE_EN
    localparam int HIT_LAT = 32;
`else
    localparam int HIT_LAT = 63;
`endif

    always #5 clk = ~clk;

    present_dec_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state     (state_in),
        .key       (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data),
        .busy      (busy)
    );

    // Offer one block, measure latency, optionally stall, then hand it off.
    task automatic run_block(input string name, input logic [63:0] ct, input logic [79:0] k,
                             input logic [63:0] exp_pt, input int exp_lat,
                             input bit junk, input int hold);
        int n;
        bit bad;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s.idle in_ready got %b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        state_in = ct;
        key_in   = k;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        state_in = '0;
        key_in   = '0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s.start busy/in_ready got %b/%b want 1/0", name, busy, in_ready);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            if (junk) begin
                in_valid = n[0];
                state_in = {$urandom(), $urandom()};
                key_in   = {16'($urandom()), $urandom(), $urandom()};
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (n != exp_lat) begin
            errors++;
            $display("FAIL %s.latency got %0d want %0d", name, n, exp_lat);
        end
        checks++;
        if (out_data !== exp_pt) begin
            errors++;
            $display("FAIL %s.plaintext got %h want %h", name, out_data, exp_pt);
        end
        $display("block %s ct=%h latency=%0d out=%h", name, ct, n, out_data);
        if (hold > 0) begin
            bad = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (out_valid !== 1'b1 || out_data !== exp_pt || in_ready !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s.hold out_valid=%b out=%h want 1 and %h", name, out_valid, out_data, exp_pt);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s.handoff in_ready/out_valid/busy got %b/%b/%b want 1/0/0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = '0;
        key_in    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset.in_ready got %b want 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset.out_valid got %b want 0", out_valid); end
        checks++;
        if (out_data !== 64'h0) begin errors++; $display("FAIL reset.out got %h want 0", out_data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset.busy got %b want 0", busy); end
        $display("reset in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
    endtask

    task automatic test_basic();
        run_block("zero_key", 64'h5579C1387B228445, KEY_ZERO, PT_ZERO, FULL_LAT, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_block("ones_key_a", 64'hE72C46C0F5945049, KEY_ONES, PT_ZERO, FULL_LAT, 1'b0, 0);
        run_block("ones_key_b", 64'h3333DCD3213210D2, KEY_ONES, PT_ONES, HIT_LAT, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_block("stall", 64'hA112FFC72F68417B, KEY_ZERO, PT_ONES, FULL_LAT, 1'b0, 10);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        in_valid = 1'b1;
        state_in = 64'hE72C46C0F5945049;
        key_in   = KEY_ONES;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        // 48 cycles after transfer: 31 KEYEXP + 1 WHITEN + 16 rounds, rc = 15.
        repeat (48) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midrst.busy_before got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL midrst.after in_ready/out_valid/out got %b/%b/%h want 1/0/0",
                     in_ready, out_valid, out_data);
        end
        $display("midrst in_ready=%b out_valid=%b", in_ready, out_valid);
        run_block("after_rst", 64'h5579C1387B228445, KEY_ZERO, PT_ZERO, FULL_LAT, 1'b0, 0);
    endtask

    task automatic test_junk_inputs();
        run_block("junk", 64'h3333DCD3213210D2, KEY_ONES, PT_ONES, FULL_LAT, 1'b1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_junk_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
